// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit stages: FSM states,
// data width and the bit-timing helper.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Returns CLKS_PER_BIT, or half of it (for the mid-bit start sample) when half is set
    function automatic int clks_per_bit(input int clock_freq, input int baud_rate, input bit half);
        int cpb;
        cpb = clock_freq / baud_rate;
        return half ? (cpb / 2) : cpb;
    endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte handshake and error-status bundle between the UART receiver and
// the memory-mapped register read logic.
interface uart_rx_frontend_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready;
    logic              framing_error;
    logic              overrun;
    logic              err_clear;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready,
        input  err_clear
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready,
        output err_clear
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing: a load of HALF or CLKS_PER_BIT
// produces a one-cycle tick exactly that many cycles later.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF         = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_half,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    logic [CW-1:0] count;
    logic          running;

    // A load issued on the tick cycle restarts the count, so bit periods chain without gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_half ? HALF_M1 : FULL_M1;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign tick = running && (count == '0);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronises serial_in, samples 8N1 frames at mid-bit
// and holds one byte on a valid/ready handshake. Define UART_RX_PARITY_EN for 8E1.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    uart_rx_frontend_if.master  rx_if
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE, 1'b0);
    localparam int HALF         = clks_per_bit(CLOCK_FREQ, BAUD_RATE, 1'b1);

    logic [1:0]        sync_q;
    logic              line;
    rx_state_t         state_q, state_d;
    logic [2:0]        bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              timer_load, timer_load_half, tick;
    logic              shift_en, frame_good, frame_bad, stop_ok;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, framing_q, overrun_q;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF         (HALF)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_half (timer_load_half),
        .tick      (tick)
    );

    // Reset to the idle-high level so a reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign line = sync_q[1];

`ifdef UART_RX_PARITY_EN
    logic parity_ok_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_ok_q <= 1'b1;
        end else if (state_q == PARITY && tick) begin
            parity_ok_q <= (line == ^shift_q);
        end
    end

    assign stop_ok = line && parity_ok_q;
`else
    assign stop_ok = line;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        timer_load      = 1'b0;
        timer_load_half = 1'b0;
        shift_en        = 1'b0;
        frame_good      = 1'b0;
        frame_bad       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!line) begin
                    timer_load      = 1'b1;
                    timer_load_half = 1'b1;
                    state_d         = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!line) begin
                        timer_load = 1'b1;
                        state_d    = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en   = 1'b1;
                    timer_load = 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    timer_load = 1'b1;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d    = IDLE;
                    frame_good = stop_ok;
                    frame_bad  = !stop_ok;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bits arrive LSB first, so each new bit enters at the top and moves down
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else if (state_q == IDLE) begin
            bit_idx_q <= '0;
        end else if (shift_en) begin
            bit_idx_q <= bit_idx_q + 1'b1;
            shift_q   <= {line, shift_q[DATA_W-1:1]};
        end
    end

    // A byte landing on the same cycle as a handshake replaces the consumed one without overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (frame_good && (!valid_q || rx_if.data_out_ready)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx_if.data_out_ready) begin
                valid_q <= 1'b0;
            end
            if (frame_good && valid_q && !rx_if.data_out_ready) begin
                overrun_q <= 1'b1;
            end else if (rx_if.err_clear) begin
                overrun_q <= 1'b0;
            end
            if (frame_bad) begin
                framing_q <= 1'b1;
            end else if (rx_if.err_clear) begin
                framing_q <= 1'b0;
            end
        end
    end

    assign rx_if.data_out       = data_q;
    assign rx_if.data_out_valid = valid_q;
    assign rx_if.framing_error  = framing_q;
    assign rx_if.overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed scenarios plus randomized
// frames, compared every cycle against a frame-completion model of the receiver.
module tb_uart_rx_frontend;

    localparam int CF   = 2_100_000;
    localparam int BR   = 100_000;
    localparam int C    = CF / BR;
    localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         good;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;

    uart_rx_frontend_if bus ();

    uart_rx_frontend #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_if     (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         rand_mode = 1'b0;
    bit         model_live = 1'b0;
    frame_t     pend[$];
    frame_t     done_f;
    logic [7:0] m_data = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;
    bit         set_fe, set_ov;
    int         valid_cycles = 0;
    logic [7:0] last_data = 8'h00;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Model: each frame resolves at the stop-bit sample edge, start + 3 + HALF + NB*C
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_data = 8'h00; m_valid = 0; m_fe = 0; m_ov = 0;
            pend.delete();
            model_live = 1'b1;
        end else begin
            set_fe = 0;
            set_ov = 0;
            if (m_valid && bus.data_out_ready) m_valid = 0;
            if (pend.size() > 0 && pend[0].t == cyc) begin
                done_f = pend.pop_front();
                if (!done_f.good) set_fe = 1;
                else if (m_valid) set_ov = 1;
                else begin
                    m_data  = done_f.b;
                    m_valid = 1;
                end
            end
            if (bus.err_clear) begin
                m_fe = 0;
                m_ov = 0;
            end
            if (set_fe) m_fe = 1;
            if (set_ov) m_ov = 1;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("data_out", bus.data_out, m_data);
            checkOutput("data_out_valid", {7'd0, bus.data_out_valid}, {7'd0, m_valid});
            checkOutput("framing_error", {7'd0, bus.framing_error}, {7'd0, m_fe});
            checkOutput("overrun", {7'd0, bus.overrun}, {7'd0, m_ov});
        end
        if (bus.data_out_valid === 1'b1) begin
            valid_cycles++;
            last_data = bus.data_out;
        end
    end

    task automatic stepCycle();
        @(negedge clk);
        if (rand_mode) begin
            bus.data_out_ready = 1'($urandom_range(0, 1));
            bus.err_clear      = ($urandom_range(0, 31) == 0);
        end else begin
            bus.err_clear = 1'b0;
        end
    endtask

    task automatic holdBit(input logic v, input int n);
        for (int k = 0; k < n; k++) begin
            stepCycle();
            serial_in = v;
        end
    endtask

    task automatic pulseErrClear();
        @(negedge clk);
        bus.err_clear = 1'b1;
        stepCycle();
    endtask

    // Drives one frame; a bad stop bit stays low only through its mid-bit sample
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                                 input int gap, input int rst_bit);
        frame_t f;
        stepCycle();
        serial_in = 1'b0;
        f.t    = cyc + 3 + HALF + NB * C;
        f.b    = b;
        f.good = stop_ok && !par_flip;
        pend.push_back(f);
        holdBit(1'b0, C - 1);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                stepCycle();
                serial_in = b[i];
                rst = 1'b1;
                holdBit(b[i], 2);
                rst = 1'b0;
                holdBit(b[i], C - 3);
            end else begin
                holdBit(b[i], C);
            end
        end
`ifdef UART_RX_PARITY_EN
        holdBit((^b) ^ par_flip, C);
`endif
        if (stop_ok) begin
            holdBit(1'b1, C);
        end else begin
            holdBit(1'b0, HALF + 1);
            holdBit(1'b1, C - HALF - 1);
        end
        holdBit(1'b1, gap);
    endtask

    initial begin
        bus.data_out_ready = 1'b0;
        bus.err_clear      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data", bus.data_out, 8'h00);
        checkOutput("reset_valid", {7'd0, bus.data_out_valid}, 8'h00);
        checkOutput("reset_fe", {7'd0, bus.framing_error}, 8'h00);
        checkOutput("reset_ov", {7'd0, bus.overrun}, 8'h00);
        rst = 1'b0;
        holdBit(1'b1, 5);

        $display("[TB] single byte 0xA5, ready held high");
        bus.data_out_ready = 1'b1;
        valid_cycles = 0;
        applyStimulus(8'hA5, 1, 0, C, -1);
        checkOutput("a5_data", last_data, 8'hA5);
        checkOutput("a5_model_data", m_data, 8'hA5);
        checkOutput("a5_valid_cycles", 8'(valid_cycles), 8'd1);
        checkOutput("a5_fe", {7'd0, bus.framing_error}, 8'h00);

        $display("[TB] overrun: 0x3C then 0x7E with ready low");
        bus.data_out_ready = 1'b0;
        applyStimulus(8'h3C, 1, 0, 0, -1);
        applyStimulus(8'h7E, 1, 0, C, -1);
        checkOutput("ovr_data", bus.data_out, 8'h3C);
        checkOutput("ovr_valid", {7'd0, bus.data_out_valid}, 8'h01);
        checkOutput("ovr_flag", {7'd0, bus.overrun}, 8'h01);
        checkOutput("ovr_model_flag", {7'd0, m_ov}, 8'h01);
        pulseErrClear();
        checkOutput("ovr_cleared", {7'd0, bus.overrun}, 8'h00);
        checkOutput("ovr_valid_kept", {7'd0, bus.data_out_valid}, 8'h01);
        bus.data_out_ready = 1'b1;
        holdBit(1'b1, 2);
        checkOutput("ovr_drained", {7'd0, bus.data_out_valid}, 8'h00);

        $display("[TB] framing error on 0x55");
        valid_cycles = 0;
        applyStimulus(8'h55, 0, 0, C, -1);
        checkOutput("fe_valid_cycles", 8'(valid_cycles), 8'd0);
        checkOutput("fe_flag", {7'd0, bus.framing_error}, 8'h01);
        pulseErrClear();
        checkOutput("fe_cleared", {7'd0, bus.framing_error}, 8'h00);

        $display("[TB] short low glitch on idle line");
        valid_cycles = 0;
        stepCycle();
        serial_in = 1'b0;
        holdBit(1'b0, HALF / 2 - 1);
        holdBit(1'b1, 3 * C);
        checkOutput("glitch_valid_cycles", 8'(valid_cycles), 8'd0);
        checkOutput("glitch_fe", {7'd0, bus.framing_error}, 8'h00);

        $display("[TB] reset during 0xFF, then 0x01");
        bus.data_out_ready = 1'b0;
        applyStimulus(8'hFF, 1, 0, C, 4);
        applyStimulus(8'h01, 1, 0, C, -1);
        checkOutput("rst_data", bus.data_out, 8'h01);
        checkOutput("rst_valid", {7'd0, bus.data_out_valid}, 8'h01);
        checkOutput("rst_ov", {7'd0, bus.overrun}, 8'h00);
        bus.data_out_ready = 1'b1;
        holdBit(1'b1, 2);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity: 0x03 good and bad");
        valid_cycles = 0;
        applyStimulus(8'h03, 1, 0, C, -1);
        checkOutput("par_ok_data", last_data, 8'h03);
        checkOutput("par_ok_cycles", 8'(valid_cycles), 8'd1);
        valid_cycles = 0;
        applyStimulus(8'h03, 1, 1, C, -1);
        checkOutput("par_bad_cycles", 8'(valid_cycles), 8'd0);
        checkOutput("par_bad_fe", {7'd0, bus.framing_error}, 8'h01);
        pulseErrClear();
`endif

        $display("[TB] randomized frames");
        rand_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 7) != 0),
`ifdef UART_RX_PARITY_EN
                          ($urandom_range(0, 7) == 0),
`else
                          1'b0,
`endif
                          $urandom_range(0, 2) * $urandom_range(0, C), -1);
        end
        rand_mode = 1'b0;
        bus.data_out_ready = 1'b1;
        holdBit(1'b1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
